fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of program_memory.
- Owns the program counter and drives the memory address; the memory returns the instruction combinationally in the same cycle.
- Latches that instruction into an instruction register (IR) and presents it to decode over a valid/ready handshake.
- Handles branch redirects (absolute or PC-relative), back-pressure and halt.

Parameters:
- ADDR_WIDTH, 4, program counter / program memory address width.
- INSTR_WIDTH, 12, instruction word width.
- RESET_ADDR, 0, PC value loaded on reset; ADDR_WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_addr  output  ADDR_WIDTH  current PC; connects to program_memory addr.
- pm_instr  input  INSTR_WIDTH  instruction word from program_memory at pc_addr, same cycle.
- instr_out  output  INSTR_WIDTH  IR contents to decode.
- instr_pc  output  ADDR_WIDTH  address from which instr_out was fetched.
- instr_valid  output  1  IR holds a valid instruction.
- instr_ready  input  1  decode accepts instr_out this cycle.
- branch_en  input  1  redirect request from decode/execute.
- branch_rel  input  1  1: target = instr_pc + sign-extended branch_target; 0: target = branch_target.
- branch_target  input  ADDR_WIDTH  absolute address, or two's-complement offset.
- halt  input  1  stop fetching.
- halted  output  1  block is in the HALTED state.

Behaviour:
- Interface decided: one clock (clk); reset is synchronous and active-high (reset).
- Reset (sampled high at a clock edge), regardless of state:
  - pc_addr=RESET_ADDR, instr_out=0, instr_pc=0, instr_valid=0, halted=0, state=RUN.
  - A reset mid-operation discards the IR and any pending branch.
- States: RUN, HALTED. There are no other states.
- RUN, define accept = !instr_valid || instr_ready.
  - Priority order: halt, then branch_en, then accept, then hold.
- halt=1:
  - Next state HALTED; instr_valid<=0; pc_addr holds.
  - A branch in the same cycle is ignored.
- branch_en=1 (halt=0):
  - pc_addr <= target; instr_valid<=0, flushing the IR whether or not instr_ready is high.
  - pm_instr this cycle is discarded.
  - If instr_ready=1 in this cycle, the handshake still counts as consumed by decode.
  - Relative target = (instr_pc + sign_extend(branch_target)) mod 2^ADDR_WIDTH; the base is the IR address, not pc_addr.
- accept=1, no branch/halt:
  - instr_out<=pm_instr; instr_pc<=pc_addr; instr_valid<=1; pc_addr<=pc_addr+1.
- accept=0, no branch/halt: pc_addr, instr_out, instr_pc and instr_valid all hold.
- Latency:
  - A fetch from address A appears on instr_out one cycle after pc_addr=A is accepted.
  - After reset, first instr_valid=1 is at the 1st edge after reset deasserts.
  - A branch costs exactly one bubble cycle (instr_valid=0), then the target instruction is valid.
- PC increment wraps: 2^ADDR_WIDTH-1 -> 0; no overflow flag. Relative targets wrap the same way.
- HALTED:
  - halted=1; instr_valid=0; pc_addr, instr_out and instr_pc hold.
  - branch_en and halt are ignored; only reset leaves HALTED.
- instr_out/instr_pc change only when instr_valid rises or a new accept occurs; they stay stable while instr_valid=1 and instr_ready=0.
- No combinational path from any input to any output; pc_addr is registered.

Test Plan:
- Sequential fetch: memory word i = 12'h100+i, instr_ready=1 held. Release reset -> instr_out 100,101,102… on consecutive cycles; instr_pc 0,1,2…; pc_addr = instr_pc+1.
- Back-pressure: drop instr_ready for 3 cycles while IR=12'h103 -> instr_out/instr_pc/pc_addr frozen at 103/3/4, instr_valid=1. Raise ready -> 104 next cycle, no word lost or duplicated.
- Absolute branch: branch_en=1, branch_rel=0, target=4'hA while instr_pc=2 -> next cycle instr_valid=0, pc_addr=A; following cycle instr_out=12'h10A, instr_pc=A.
- Relative branches and wrap:
  - instr_pc=1, branch_rel=1, target=4'hE (-2) -> pc_addr=F, then instr_out=10F.
  - Next sequential fetch wraps to addr 0 (instr_out=100).
- Halt: halt=1 at instr_pc=5, asserted together with branch_en=1 -> halted=1, instr_valid=0, pc_addr holds 6 (branch ignored). Later branch_en/halt pulses cause no change.
- Reset mid-run: assert reset for 1 cycle while HALTED or while instr_ready=0 -> pc_addr=RESET_ADDR, instr_valid=0, halted=0, then sequential fetch from RESET_ADDR resumes.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch <-> program memory / decode signal bundle.
// The master side is the fetch unit. The slave side is the memory and decode environment.
interface fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned INSTR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]  pc_addr;
    logic [INSTR_WIDTH-1:0] pm_instr;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   branch_en;
    logic                   branch_rel;
    logic [ADDR_WIDTH-1:0]  branch_target;
    logic                   halt;
    logic                   halted;

    modport master (
        output pc_addr, instr_out, instr_pc, instr_valid, halted,
        input  pm_instr, instr_ready, branch_en, branch_rel, branch_target, halt
    );

    modport slave (
        input  pc_addr, instr_out, instr_pc, instr_valid, halted,
        output pm_instr, instr_ready, branch_en, branch_rel, branch_target, halt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, latches the memory word into the IR and hands it to
// decode over valid/ready. It also handles branch redirects and a sticky halt.
module fetch_unit #(
    parameter int unsigned          ADDR_WIDTH  = 4,
    parameter int unsigned          INSTR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic      clk,
    input  logic      reset,
    fetch_unit_if.master bus
);
    typedef enum logic {StRun, StHalted} state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]  r_ipc;
    logic                   r_valid;

    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  w_pc_nxt;
    logic [INSTR_WIDTH-1:0] w_instr_nxt;
    logic [ADDR_WIDTH-1:0]  w_ipc_nxt;
    logic                   w_valid_nxt;
    logic                   w_accept;
    logic [ADDR_WIDTH-1:0]  w_target;

    // IR is free when empty or being consumed this cycle.
    assign w_accept = !r_valid || bus.instr_ready;

    // Same-width addition is already the sign-extended offset, modulo 2^ADDR_WIDTH.
    // The relative base is the IR address.
    assign w_target = bus.branch_rel ? (r_ipc + bus.branch_target) : bus.branch_target;

    // Next-state: halt > branch > accept > hold; HALTED only leaves on reset.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_ipc_nxt   = r_ipc;
        w_valid_nxt = r_valid;
        unique case (r_state)
            StRun: begin
                if (bus.halt) begin
                    w_state_nxt = StHalted;
                    w_valid_nxt = 1'b0;
                end else if (bus.branch_en) begin
                    // Word fetched this cycle belongs to the old path; drop it and flush IR.
                    w_pc_nxt    = w_target;
                    w_valid_nxt = 1'b0;
                end else if (w_accept) begin
                    w_instr_nxt = bus.pm_instr;
                    w_ipc_nxt   = r_pc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pc + ADDR_WIDTH'(1);
                end
            end
            StHalted: begin
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StRun;
            r_pc    <= RESET_ADDR;
            r_instr <= '0;
            r_ipc   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_ipc   <= w_ipc_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign bus.pc_addr     = r_pc;
    assign bus.instr_out   = r_instr;
    assign bus.instr_pc    = r_ipc;
    assign bus.instr_valid = r_valid;
    assign bus.halted      = (r_state == StHalted);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic. Outputs are compared
// every cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;
    localparam int unsigned AW = 4;
    localparam int unsigned IW = 12;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic reset;

    fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_ADDR(4'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] mem [DEPTH];
    assign bus.pm_instr = mem[bus.pc_addr];

    int checks = 0;
    int errors = 0;

    // Model state.
    int m_pc, m_ir, m_ipc;
    bit m_valid, m_halted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock of the fetch rules, using the inputs present before the edge.
    task automatic model_edge();
        int off;
        if (reset) begin
            m_pc = 0; m_ir = 0; m_ipc = 0; m_valid = 0; m_halted = 0;
        end else if (m_halted) begin
            m_valid = 0;
        end else if (bus.halt) begin
            m_halted = 1; m_valid = 0;
        end else if (bus.branch_en) begin
            if (bus.branch_rel) begin
                off  = (bus.branch_target >= 8) ? int'(bus.branch_target) - 16
                                                : int'(bus.branch_target);
                m_pc = (m_ipc + off + 16) % 16;
            end else begin
                m_pc = int'(bus.branch_target);
            end
            m_valid = 0;
        end else if (!m_valid || bus.instr_ready) begin
            m_ir    = int'(mem[m_pc]);
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 1) % 16;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("pc_addr",     32'(bus.pc_addr),     32'(m_pc));
        chk("instr_out",   32'(bus.instr_out),   32'(m_ir));
        chk("instr_pc",    32'(bus.instr_pc),    32'(m_ipc));
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        chk("halted",      32'(bus.halted),      32'(m_halted));
    endtask

    // Literal expectations taken straight from the scenario being exercised.
    task automatic expect_ir(input string tag, input int ir, input int ipc, input int pc,
                             input bit valid);
        chk({tag, ".instr_out"},   32'(bus.instr_out),   32'(ir));
        chk({tag, ".instr_pc"},    32'(bus.instr_pc),    32'(ipc));
        chk({tag, ".pc_addr"},     32'(bus.pc_addr),     32'(pc));
        chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(valid));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 12'h100 + 12'(i);
        reset = 1'b1;
        bus.instr_ready = 1'b1;
        bus.branch_en = 1'b0;
        bus.branch_rel = 1'b0;
        bus.branch_target = '0;
        bus.halt = 1'b0;

        // Reset state.
        cycle();
        cycle();
        expect_ir("reset", 0, 0, 0, 0);
        chk("reset.halted", 32'(bus.halted), 32'd0);

        // Sequential fetch.
        reset = 1'b0;
        cycle();
        expect_ir("seq0", 12'h100, 0, 1, 1);
        cycle();
        cycle();
        cycle();
        expect_ir("seq3", 12'h103, 3, 4, 1);

        // Back-pressure for three cycles.
        bus.instr_ready = 1'b0;
        repeat (3) cycle();
        expect_ir("stall", 12'h103, 3, 4, 1);
        bus.instr_ready = 1'b1;
        cycle();
        expect_ir("unstall", 12'h104, 4, 5, 1);

        // Absolute branch to A: one bubble, then the target word.
        bus.branch_en = 1'b1;
        bus.branch_target = 4'hA;
        cycle();
        chk("abs.bubble", 32'(bus.instr_valid), 32'd0);
        chk("abs.pc", 32'(bus.pc_addr), 32'hA);
        bus.branch_en = 1'b0;
        cycle();
        expect_ir("abs.tgt", 12'h10A, 10, 11, 1);

        // Go back to 0, fetch up to instr_pc=1, then relative branch by -2.
        bus.branch_en = 1'b1;
        bus.branch_target = 4'h0;
        cycle();
        bus.branch_en = 1'b0;
        cycle();
        cycle();
        expect_ir("pre_rel", 12'h101, 1, 2, 1);
        bus.branch_en = 1'b1;
        bus.branch_rel = 1'b1;
        bus.branch_target = 4'hE;
        cycle();
        chk("rel.pc", 32'(bus.pc_addr), 32'hF);
        chk("rel.bubble", 32'(bus.instr_valid), 32'd0);
        bus.branch_en = 1'b0;
        bus.branch_rel = 1'b0;
        cycle();
        expect_ir("rel.tgt", 12'h10F, 15, 0, 1);
        cycle();
        expect_ir("wrap", 12'h100, 0, 1, 1);
        repeat (5) cycle();
        expect_ir("pre_halt", 12'h105, 5, 6, 1);

        // Halt wins over a simultaneous branch.
        bus.halt = 1'b1;
        bus.branch_en = 1'b1;
        bus.branch_target = 4'h3;
        cycle();
        chk("halt.halted", 32'(bus.halted), 32'd1);
        chk("halt.pc", 32'(bus.pc_addr), 32'h6);
        chk("halt.valid", 32'(bus.instr_valid), 32'd0);
        bus.halt = 1'b0;
        cycle();
        bus.branch_en = 1'b0;
        cycle();
        bus.halt = 1'b1;
        cycle();
        bus.halt = 1'b0;
        cycle();
        chk("halted.pc", 32'(bus.pc_addr), 32'h6);
        chk("halted.ipc", 32'(bus.instr_pc), 32'h5);

        // Reset out of HALTED, then resume.
        reset = 1'b1;
        cycle();
        expect_ir("rst_halt", 0, 0, 0, 0);
        chk("rst_halt.halted", 32'(bus.halted), 32'd0);
        reset = 1'b0;
        cycle();
        cycle();
        expect_ir("resume", 12'h101, 1, 2, 1);

        // Reset while decode is stalled.
        bus.instr_ready = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        expect_ir("rst_stall", 0, 0, 0, 0);
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        cycle();
        expect_ir("resume2", 12'h100, 0, 1, 1);

        // Random traffic with random memory contents.
        for (int i = 0; i < DEPTH; i++) mem[i] = 12'($urandom);
        for (int n = 0; n < 600; n++) begin
            reset             = ($urandom_range(0, 99) < 2);
            bus.instr_ready   = ($urandom_range(0, 99) < 70);
            bus.branch_en     = ($urandom_range(0, 99) < 12);
            bus.branch_rel    = 1'($urandom);
            bus.branch_target = 4'($urandom);
            bus.halt          = ($urandom_range(0, 99) < 3);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
